// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle add/subtract, CHUNK bits per clock through one ripple slice,
// with valid/ready handshakes on both sides and a signed-overflow flag.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CHUNK-1:0] a_k, b_k;
    logic [CHUNK:0]   slice;
    logic             last;
    int               base;

    always_comb begin
        base  = int'(cnt_q) * CHUNK;
        a_k   = a_q[base +: CHUNK];
        b_k   = b_q[base +: CHUNK];
        slice = {1'b0, a_k} + {1'b0, b_k} + {{CHUNK{1'b0}}, carry_q};
        last  = cnt_q == CW'(NCHUNK - 1);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in1;
                b_d     = sub ? ~in2 : in2;
                carry_d = sub ? 1'b1 : c_in;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[base +: CHUNK] = slice[CHUNK-1:0];
                carry_d = slice[CHUNK];
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    c_out_d = slice[CHUNK];
                    // carry into the MSB recovered from the MSB's own sum bit
                    ovf_d   = a_k[CHUNK-1] ^ b_k[CHUNK-1] ^ slice[CHUNK-1] ^ slice[CHUNK];
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: directed checks of chunked_serial_adder across four (WIDTH,CHUNK) builds.
module tb_chunked_serial_adder;
    localparam int WS [4] = '{16, 16, 32, 8};
    localparam int CS [4] = '{4, 16, 8, 1};
    localparam int NC [4] = '{4, 1, 4, 8};

    logic        clk, rst_n;
    logic        in_valid_a [4];
    logic        out_ready_a [4];
    logic        c_in_a [4];
    logic        sub_a [4];
    logic [31:0] in1_a [4];
    logic [31:0] in2_a [4];
    wire         in_ready_a [4];
    wire         out_valid_a [4];
    wire         c_out_a [4];
    wire         ovf_a [4];
    wire  [31:0] sum_a [4];
    int          checks = 0;
    int          errors = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = WS[g];
        logic [W-1:0] s;
        chunked_serial_adder #(.WIDTH(W), .CHUNK(CS[g])) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid_a[g]), .in_ready(in_ready_a[g]),
            .in1(in1_a[g][W-1:0]), .in2(in2_a[g][W-1:0]),
            .c_in(c_in_a[g]), .sub(sub_a[g]),
            .out_valid(out_valid_a[g]), .out_ready(out_ready_a[g]),
            .sum(s), .c_out(c_out_a[g]), .ovf(ovf_a[g])
        );
        assign sum_a[g] = 32'(s);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] ref_op(int w, logic [31:0] a, logic [31:0] b, logic ci, logic sb);
        longint unsigned m, bb, full, low, cin;
        m    = (64'd1 << w) - 1;
        bb   = sb ? (~64'(b)) & m : 64'(b);
        cin  = (sb || ci) ? 64'd1 : 64'd0;
        full = 64'(a) + bb + cin;
        low  = (64'(a) & (m >> 1)) + (bb & (m >> 1)) + cin;
        return {1'(low >> (w - 1)) ^ 1'(full >> w), 1'(full >> w), 32'(full & m)};
    endfunction

    task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb, output int lat);
        int n = 0;
        while (!in_ready_a[i] && n < 50) begin @(posedge clk); #1; n++; end
        chk("in_ready_idle", 32'(in_ready_a[i]), 1);
        in1_a[i] = a; in2_a[i] = b; c_in_a[i] = ci; sub_a[i] = sb; in_valid_a[i] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[i] = 1'b0;
        lat = 1;
        while (!out_valid_a[i] && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic op_chk(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sb,
                          input logic [31:0] es, input logic eco, input logic eov);
        int lat;
        do_op(i, a, b, ci, sb, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(NC[i] + 1));
        chk({tag, "_sum"}, sum_a[i], es);
        chk({tag, "_cout"}, 32'(c_out_a[i]), 32'(eco));
        chk({tag, "_ovf"}, 32'(ovf_a[i]), 32'(eov));
        out_ready_a[i] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[i] = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] a, b, mask;
        logic ci, sb;
        logic [33:0] r;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_a[i] = 0; out_ready_a[i] = 0; c_in_a[i] = 0; sub_a[i] = 0;
            in1_a[i] = 0; in2_a[i] = 0;
        end
        #2;
        chk("rst_in_ready", 32'(in_ready_a[0]), 1);
        chk("rst_out_valid", 32'(out_valid_a[0]), 0);
        chk("rst_sum", sum_a[0], 0);
        chk("rst_cout_ovf", {30'd0, c_out_a[0], ovf_a[0]}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        op_chk("add", 0, 3245, 16785, 0, 0, 20030, 0, 0);
        op_chk("add_cin", 0, 3245, 16785, 1, 0, 20031, 0, 0);
        op_chk("max", 0, 25000, 40535, 0, 0, 65535, 0, 0);
        op_chk("wrap", 0, 25001, 40535, 0, 0, 0, 1, 0);
        op_chk("wrap_cin", 0, 25001, 40535, 1, 0, 1, 1, 0);
        op_chk("sub_borrow", 0, 100, 200, 1, 1, 65436, 0, 0);
        op_chk("sub", 0, 200, 100, 0, 1, 100, 1, 0);
        op_chk("ovf_add", 0, 32767, 1, 0, 0, 32768, 0, 1);
        op_chk("ovf_sub", 0, 32768, 1, 0, 1, 32767, 1, 1);

        // in_valid held high, operands disturbed during RUN, then backpressure
        in1_a[0] = 32769; in2_a[0] = 32769; c_in_a[0] = 0; sub_a[0] = 0; in_valid_a[0] = 1;
        @(posedge clk); #1;
        n = 1;
        chk("busy_after_accept", 32'(in_ready_a[0]), 0);
        in1_a[0] = 0; in2_a[0] = 12345; sub_a[0] = 1; c_in_a[0] = 1;
        while (!out_valid_a[0] && n < 100) begin @(posedge clk); #1; n++; end
        chk("held_lat", 32'(n), 5);
        in_valid_a[0] = 0;
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", 32'(out_valid_a[0]), 1);
            chk("bp_sum", sum_a[0], 2);
            chk("bp_cout_ovf", {30'd0, c_out_a[0], ovf_a[0]}, 3);
            @(posedge clk); #1;
        end
        out_ready_a[0] = 1;
        @(posedge clk); #1;
        out_ready_a[0] = 0;
        chk("handoff_in_ready", 32'(in_ready_a[0]), 1);
        chk("handoff_out_valid", 32'(out_valid_a[0]), 0);
        chk("handoff_sum", sum_a[0], 2);

        // reset two RUN edges into an operation
        in1_a[0] = 5000; in2_a[0] = 6000; sub_a[0] = 0; c_in_a[0] = 0; in_valid_a[0] = 1;
        @(posedge clk); #1;
        in_valid_a[0] = 0;
        @(posedge clk); @(posedge clk); #1;
        chk("mid_run_busy", 32'(in_ready_a[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid_a[0]), 0);
        chk("arst_sum", sum_a[0], 0);
        chk("arst_in_ready", 32'(in_ready_a[0]), 1);
        #3;
        rst_n = 1'b1;
        op_chk("after_rst", 0, 1, 1, 0, 0, 2, 0, 0);

        for (int i = 1; i < 4; i++) begin
            mask = WS[i] == 32 ? 32'hFFFF_FFFF : (32'd1 << WS[i]) - 1;
            for (int k = 0; k < 5; k++) begin
                a = $urandom & mask; b = $urandom & mask;
                ci = 1'($urandom); sb = 1'($urandom);
                r = ref_op(WS[i], a, b, ci, sb);
                op_chk($sformatf("sweep%0d_%0d", i, k), i, a, b, ci, sb, r[31:0], r[32], r[33]);
            end
        end
        op_chk("w8c1_wrap", 3, 255, 1, 0, 0, 0, 1, 0);
        op_chk("w32_ovf", 2, 32'h7FFF_FFFF, 1, 0, 0, 32'h8000_0000, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the 16-bit combinational ripple-carry adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through one CHUNK-bit ripple slice, with a registered carry between slices.
- Trades latency for area.
- Valid/ready handshakes on input and output, so it drops into pipelined datapaths.
- Adds a subtract mode and a signed-overflow flag.

Parameters:
- WIDTH, 16, operand/sum width in bits.
- CHUNK, 4, bits added per cycle. WIDTH % CHUNK must be 0; CHUNK == WIDTH gives a single-cycle RUN.
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/mode valid.
- in_ready  out  1  block can accept a new operation.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- c_in  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: in1+in2+c_in; 1: in1-in2, computed as in1+~in2+1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of MSB. In subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; sum=0; c_out=0; ovf=0; chunk counter=0; internal operand and carry registers=0. Reset asserted mid-operation aborts it immediately, with no partial result emitted.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - Accept on a rising edge with in_valid=1.
  - At accept: latch in1, latch (sub ? ~in2 : in2), carry <= (sub ? 1 : c_in), counter <= 0, go to RUN.
  - in_valid=0: stay in IDLE.
- RUN, each cycle for chunk k = counter:
  - {carry, sum[k*CHUNK +: CHUNK]} <= A[k*CHUNK +: CHUNK] + B'[k*CHUNK +: CHUNK] + carry.
  - counter increments.
  - On the last chunk (k == NCHUNK-1):
    - c_out <= final carry.
    - ovf <= carry into bit WIDTH-1 XOR final carry.
    - Go to DONE.
  - RUN ignores in_valid and out_ready.
- Latency: out_valid rises NCHUNK+1 clock edges after the accept edge (accept edge, NCHUNK RUN edges, DONE visible after the last RUN edge). Default: 5 edges, i.e. out_valid high in the 5th cycle after the accept cycle.
- DONE:
  - sum, c_out and ovf are held stable while out_valid=1 and out_ready=0 (backpressure, unbounded).
  - On an edge with out_ready=1: go to IDLE; outputs keep their values, out_valid drops.
  - No accept in the same cycle as the DONE handoff; minimum issue interval is NCHUNK+2 cycles.
- In RUN, sum bits not yet written hold the previous result; only out_valid qualifies sum.
- Wrap-around: sum is modulo 2^WIDTH, with the carry reported on c_out.
- Input changes while in_ready=0 have no effect.

Test Plan:
- Plain add: in1=3245, in2=16785, c_in=0, sub=0 -> sum=20030, c_out=0, ovf=0. Repeat with c_in=1 -> sum=20031.
- Carry and wrap: 25000+40535 -> sum=65535, c_out=0. 25001+40535, c_in=0 -> sum=0, c_out=1. Same with c_in=1 -> sum=1, c_out=1.
- Subtract and overflow:
  - 100-200, sub=1 -> sum=65436, c_out=0.
  - 200-100 -> sum=100, c_out=1.
  - 32767+1 -> sum=32768, ovf=1.
  - 32768-1 (sub) -> sum=32767, ovf=1.
- Timing and backpressure:
  - Defaults: in_valid held high -> in_ready low the cycle after accept; out_valid high exactly 5 edges after accept.
  - out_ready=0 for 10 cycles -> sum/c_out/ovf stable throughout.
  - out_ready=1 -> in_ready=1 next cycle.
  - in1/in2 changed during RUN -> result unaffected.
- Reset mid-RUN: rst_n low after 2 RUN cycles -> out_valid=0, sum=0, in_ready=1 immediately, asynchronously. Next operation 1+1 -> sum=2.
- Parameter sweep: (WIDTH,CHUNK) = (16,16), (32,8), (8,1).
  - Random operands, sub, c_in vs reference model; latency = NCHUNK+1 in every case.
  - (8,1): 255+1 -> sum=0, c_out=1.
